// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs a single-outstanding
// req/gnt/rvalid handshake to imem and registers {pc, instr} onto the IF/ID bus.
module fetch_pc_ctrl #(
  parameter int              PC_W     = 30,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [PC_W-1:0]         redirect_pc,
  input  logic                    id_ready,
  output logic                    imem_req,
  output logic [PC_W-1:0]         imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [INSTR_W-1:0]      imem_rdata,
  output logic                    if_id_valid,
  output logic [PC_W+INSTR_W-1:0] if_id_bus,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t               state, state_nx;
  logic [PC_W-1:0]      pc, pc_nx;
  logic                 drop, drop_nx;
  logic [PC_W-1:0]      out_pc, out_pc_nx;
  logic [INSTR_W-1:0]   out_instr, out_instr_nx;
  logic                 valid_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      drop        <= drop_nx;
      out_pc      <= out_pc_nx;
      out_instr   <= out_instr_nx;
      if_id_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    drop_nx      = drop;
    out_pc_nx    = out_pc;
    out_instr_nx = out_instr;
    valid_nx     = if_id_valid;

    case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ: begin
        if (imem_gnt) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop) begin
            drop_nx  = 1'b0;
            state_nx = S_REQ;
          end else begin
            out_pc_nx    = pc;
            out_instr_nx = imem_rdata;
            valid_nx     = 1'b1;
            pc_nx        = pc + PC_W'(1);
            state_nx     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (id_ready) begin
          valid_nx     = 1'b0;
          out_pc_nx    = '0;
          out_instr_nx = '0;
          state_nx     = S_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // A redirect flushes the bus; a request already granted must have its response dropped.
    if (redirect_valid) begin
      pc_nx        = redirect_pc;
      valid_nx     = 1'b0;
      out_pc_nx    = '0;
      out_instr_nx = '0;
      state_nx     = S_REQ;
      drop_nx      = 1'b0;
      if ((state == S_REQ && imem_gnt) || (state == S_WAIT && !imem_rvalid)) begin
        state_nx = S_WAIT;
        drop_nx  = 1'b1;
      end
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign busy      = (state == S_REQ) || (state == S_WAIT);
  assign if_id_bus = {out_pc, out_instr};

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a simple in-bench instruction memory model;
// a second instance checks PC wrap-around from the top of the address space.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        id_ready;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [61:0] if_id_bus;
  logic        busy;

  logic        imem_req_w;
  logic [29:0] imem_addr_w;
  logic        if_id_valid_w;
  logic [61:0] if_id_bus_w;
  logic        busy_w;

  int          tests_run;
  int          tests_failed;

  int          gnt_wait;
  int          rv_delay;
  int          rv_cnt;
  logic [29:0] rd_addr;

  fetch_pc_ctrl dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_bus(if_id_bus), .busy(busy)
  );

  fetch_pc_ctrl #(.RESET_PC(30'h3FFF_FFFF)) dut_wrap (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid_w), .if_id_bus(if_id_bus_w), .busy(busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs, let the memory model answer, advance past the edge.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic redir, input logic [29:0] rpc);
    logic        g;
    logic [29:0] a;
    reset          = rst;
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    g = imem_req && (gnt_wait == 0);
    if (imem_req && gnt_wait > 0) gnt_wait--;
    imem_gnt    = g;
    imem_rvalid = (rv_cnt == 1);
    imem_rdata  = imem_rvalid ? ({2'b00, rd_addr} ^ 32'hA5A5_0000) : 32'h0;
    a = imem_addr;
    @(posedge clk);
    #1;
    if (rv_cnt > 0) rv_cnt--;
    if (g === 1'b1) begin
      rv_cnt  = rv_delay;
      rd_addr = a;
    end
    if (rst) rv_cnt = 0;
  endtask

  function automatic logic [63:0] busOf(input logic [29:0] p);
    return {2'b00, p, {2'b00, p} ^ 32'hA5A5_0000};
  endfunction

  initial begin
    logic [29:0] wrap_pc;
    tests_run      = 0;
    tests_failed   = 0;
    gnt_wait       = 0;
    rv_delay       = 1;
    rv_cnt         = 0;
    rd_addr        = '0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;

    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("rst_valid", {63'b0, if_id_valid}, 64'd0);
    checkOutput("rst_bus", {2'b0, if_id_bus}, 64'd0);
    checkOutput("rst_req", {63'b0, imem_req}, 64'd0);
    checkOutput("rst_busy", {63'b0, busy}, 64'd0);
    checkOutput("rst_valid_wrap", {63'b0, if_id_valid_w}, 64'd0);

    // Streaming fetch: first valid 3 cycles after reset release, then every 3 cycles.
    applyStimulus(0, 1, 0, 0);
    checkOutput("first_req", {63'b0, imem_req}, 64'd1);
    checkOutput("first_addr", {34'b0, imem_addr}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("wait_busy", {63'b0, busy}, 64'd1);
      checkOutput("wait_noreq", {63'b0, imem_req}, 64'd0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("stream_valid", {63'b0, if_id_valid}, 64'd1);
      checkOutput("stream_bus", {2'b0, if_id_bus}, busOf(30'(k)));
      wrap_pc = 30'h3FFF_FFFF + 30'(k);
      checkOutput("wrap_pc", {34'b0, if_id_bus_w[61:32]}, {34'b0, wrap_pc});
      applyStimulus(0, 1, 0, 0);
      checkOutput("stream_clr", {63'b0, if_id_valid}, 64'd0);
      checkOutput("stream_next_addr", {34'b0, imem_addr}, 64'(k + 1));
    end

    // Backpressure while holding pc 4.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("bp_bus", {2'b0, if_id_bus}, busOf(30'd4));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("bp_hold_valid", {63'b0, if_id_valid}, 64'd1);
      checkOutput("bp_hold_bus", {2'b0, if_id_bus}, busOf(30'd4));
      checkOutput("bp_hold_req", {63'b0, imem_req}, 64'd0);
    end
    applyStimulus(0, 1, 0, 0);
    checkOutput("bp_release_valid", {63'b0, if_id_valid}, 64'd0);
    checkOutput("bp_release_bus", {2'b0, if_id_bus}, 64'd0);
    checkOutput("bp_release_addr", {34'b0, imem_addr}, 64'd5);

    // Grant withheld for 4 cycles.
    gnt_wait = 4;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("nogt_req", {63'b0, imem_req}, 64'd1);
      checkOutput("nogt_addr", {34'b0, imem_addr}, 64'd5);
    end
    applyStimulus(0, 1, 0, 0);
    checkOutput("gnt_late_req", {63'b0, imem_req}, 64'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("gnt_late_bus", {2'b0, if_id_bus}, busOf(30'd5));
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("pc7_addr", {34'b0, imem_addr}, 64'd7);

    // Redirect while waiting at pc 7; stale response arrives 2 cycles later.
    rv_delay = 3;
    applyStimulus(0, 1, 0, 0);
    rv_delay = 1;
    applyStimulus(0, 1, 1, 30'h100);
    checkOutput("rdw_busy", {63'b0, busy}, 64'd1);
    checkOutput("rdw_valid", {63'b0, if_id_valid}, 64'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rdw_still_wait", {63'b0, imem_req}, 64'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rdw_drop_valid", {63'b0, if_id_valid}, 64'd0);
    checkOutput("rdw_req", {63'b0, imem_req}, 64'd1);
    checkOutput("rdw_addr", {34'b0, imem_addr}, 64'h100);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rdw_bus", {2'b0, if_id_bus}, busOf(30'h100));
    applyStimulus(0, 1, 0, 0);

    // Redirect coincident with grant.
    applyStimulus(0, 1, 1, 30'h200);
    checkOutput("rdg_req", {63'b0, imem_req}, 64'd0);
    checkOutput("rdg_busy", {63'b0, busy}, 64'd1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rdg_valid", {63'b0, if_id_valid}, 64'd0);
    checkOutput("rdg_addr", {34'b0, imem_addr}, 64'h200);
    checkOutput("rdg_req2", {63'b0, imem_req}, 64'd1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rdg_bus", {2'b0, if_id_bus}, busOf(30'h200));
    applyStimulus(0, 1, 0, 0);

    // Redirect coincident with rvalid.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 30'h300);
    checkOutput("rdr_valid", {63'b0, if_id_valid}, 64'd0);
    checkOutput("rdr_bus", {2'b0, if_id_bus}, 64'd0);
    checkOutput("rdr_addr", {34'b0, imem_addr}, 64'h300);
    checkOutput("rdr_req", {63'b0, imem_req}, 64'd1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rdr_bus2", {2'b0, if_id_bus}, busOf(30'h300));

    // Redirect while holding an instruction.
    applyStimulus(0, 0, 1, 30'h400);
    checkOutput("rdh_valid", {63'b0, if_id_valid}, 64'd0);
    checkOutput("rdh_bus", {2'b0, if_id_bus}, 64'd0);
    checkOutput("rdh_addr", {34'b0, imem_addr}, 64'h400);

    // Reset mid-WAIT.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("rstw_valid", {63'b0, if_id_valid}, 64'd0);
    checkOutput("rstw_bus", {2'b0, if_id_bus}, 64'd0);
    checkOutput("rstw_req", {63'b0, imem_req}, 64'd0);
    checkOutput("rstw_busy", {63'b0, busy}, 64'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rstw_addr", {34'b0, imem_addr}, 64'd0);
    checkOutput("rstw_req2", {63'b0, imem_req}, 64'd1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rstw_bus2", {2'b0, if_id_bus}, busOf(30'd0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
